// File: rtl/fastram_bus_bridge_pkg.sv
// Shared definitions for the 68000 fast-RAM bridge: FSM encoding, default window,
// active-low strobe levels and the address-window decode.
package fastram_bus_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPass    = 3'd1,
    StClaim   = 3'd2,
    StWait    = 3'd3,
    StAck     = 3'd4,
    StRelease = 3'd5
  } state_e;

  // Strobe levels shared with the SDRAM controller
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam logic [3:0] DEF_WIN_LO         = 4'h0;
  localparam logic [3:0] DEF_WIN_HI         = 4'h3;
  localparam logic [7:0] DEF_TIMEOUT_CYCLES = 8'd200;

  // A is the word address A[23:1]; the vector hole covers bytes 0x000000-0x000007
  function automatic logic win_hit(input logic [23:1] a, input logic [3:0] lo,
                                   input logic [3:0] hi, input logic hole);
    return (a[23:20] >= lo) && (a[23:20] <= hi) && !(hole && (a[23:3] == 21'd0));
  endfunction

endpackage

// File: rtl/fastram_bus_bridge_strobe_sync.sv
// Two-flop synchroniser for asynchronous active-low strobes; resets to the inactive level.
module fastram_bus_bridge_strobe_sync
  import fastram_bus_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= {WIDTH{STROBE_OFF}};
      q      <= {WIDTH{STROBE_OFF}};
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/fastram_bus_bridge.sv
// 68000 front end for the SDRAM controller: strobe sync, window decode, request latch, DTACK.
// Optional WAIT-state timeout with bus error is built when FASTRAM_TIMEOUT_EN is defined.
module fastram_bus_bridge
  import fastram_bus_bridge_pkg::*;
#(
  parameter logic [3:0] WIN_LO   = DEF_WIN_LO,
  parameter logic [3:0] WIN_HI   = DEF_WIN_HI,
  parameter logic       VEC_HOLE = 1'b1
`ifdef FASTRAM_TIMEOUT_EN
  , parameter logic [7:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_as,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic        cpu_rw,
  input  logic [23:1] cpu_a,
  input  logic        sd_valid,
  input  logic        sd_ready,
  output logic        sd_as,
  output logic        sd_uds,
  output logic        sd_lds,
  output logic        sd_rw,
  output logic [23:1] sd_a,
  output logic        dtack,
  output logic        dbuf_oe,
  output logic        dbuf_dir,
  output logic        data_le,
  output logic        berr
);

  logic [3:0] sync_q;
  logic       as_s, uds_s, lds_s, rw_s;
  state_e     state_q, state_d;
  logic       start, hit, abort, latch, busy, oe_on;
  logic       to_set, to_q;

  fastram_bus_bridge_strobe_sync #(
    .WIDTH(4)
  ) u_strobe_sync (
    .clk(clk),
    .rst(rst),
    .d  ({cpu_as, cpu_uds, cpu_lds, cpu_rw}),
    .q  (sync_q)
  );

  assign {as_s, uds_s, lds_s, rw_s} = sync_q;

  assign start = (as_s == STROBE_ON) && ((uds_s == STROBE_ON) || (lds_s == STROBE_ON));
  assign hit   = win_hit(cpu_a, WIN_LO, WIN_HI, VEC_HOLE);
  // CPU giving up the cycle, or the controller dropping back into init, ends a claim
  assign abort = (as_s == STROBE_OFF) || sd_ready;

`ifdef FASTRAM_TIMEOUT_EN
  logic [7:0] cnt_q;

  assign to_set = (state_q == StWait) && !abort && (sd_valid == STROBE_OFF) &&
                  (cnt_q == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      if (state_q == StClaim) begin
        cnt_q <= 8'd0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (state_d == StRelease) begin
        to_q <= 1'b0;
      end else if (to_set) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  assign to_set = 1'b0;
  assign to_q   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (hit && !sd_ready) begin
            state_d = StClaim;
            latch   = 1'b1;
          end else begin
            state_d = StPass;
          end
        end
      end
      StPass:    if (as_s == STROBE_OFF) state_d = StIdle;
      StClaim:   state_d = abort ? StRelease : StWait;
      StWait: begin
        if (abort) begin
          state_d = StRelease;
        end else if ((sd_valid == STROBE_ON) || to_set) begin
          state_d = StAck;
        end
      end
      StAck:     if (abort) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sd_a    <= '0;
      sd_rw   <= 1'b1;
      sd_uds  <= STROBE_OFF;
      sd_lds  <= STROBE_OFF;
    end else begin
      state_q <= state_d;
      if (latch) begin
        sd_a   <= cpu_a;
        sd_rw  <= rw_s;
        sd_uds <= uds_s;
        sd_lds <= lds_s;
      end else if (state_d == StRelease) begin
        sd_uds <= STROBE_OFF;
        sd_lds <= STROBE_OFF;
      end
    end
  end

  assign busy     = (state_q == StClaim) || (state_q == StWait) || (state_q == StAck);
  assign data_le  = (state_q == StWait) && !abort && (sd_valid == STROBE_ON);
  // Writes drive the buffer from CLAIM; reads only once the controller has data
  assign oe_on    = (state_q == StAck) || data_le ||
                    (((state_q == StClaim) || (state_q == StWait)) && !sd_rw);
  assign sd_as    = busy ? STROBE_ON : STROBE_OFF;
  assign dbuf_dir = busy && sd_rw;
  assign dbuf_oe  = oe_on ? STROBE_ON : STROBE_OFF;
  assign dtack    = ((state_q == StAck) && !to_q) ? STROBE_ON : STROBE_OFF;
  assign berr     = to_q ? STROBE_ON : STROBE_OFF;

endmodule
